add_share_scheduler: RTL and testbench

ADD_SHARE_SCHEDULER -- requirements
Module: add_share_scheduler

---
 rtl/add_share_scheduler_pkg.sv | 12 +
 rtl/add_share_scheduler_cla.sv | 16 +
 rtl/add_share_scheduler.sv | 116 +++++++++++
 tb/tb_add_share_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_share_scheduler_pkg.sv
// Shared definitions for the two-requester multi-word add scheduler.
package add_share_scheduler_pkg;

   localparam int WIDTH_DEF = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

endpackage

// File: rtl/add_share_scheduler_cla.sv
// Combinational word adder with carry-in/carry-out, shared by both requesters.
module cla_word_add
   import add_share_scheduler_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/add_share_scheduler.sv
// Arbitrates one word adder between two requesters; multi-word operations
// hold the lock and chain carry until the requester's last word.
//
//   state | meaning
//   IDLE  | no operation in flight; round-robin grant, carry-in 0
//   LOCK0 | requester 0 mid-operation; only it is served, carry-in = carry_q
//   LOCK1 | requester 1 mid-operation; only it is served, carry-in = carry_q
module add_share_scheduler
   import add_share_scheduler_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_last,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_last,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_id,
   output logic             res_last
);

   state_t           state, state_nx;
   logic             rr, rr_nx;
   logic             carry_q;
   logic             grant0, grant1;
   logic             can_take, xfer;
   logic             op_id, op_last, cin, cout;
   logic [WIDTH-1:0] op_a, op_b, sum;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      case (state)
         IDLE: begin
            if (req0_valid && (!req1_valid || !rr)) grant0 = 1'b1;
            else if (req1_valid)                    grant1 = 1'b1;
         end
         LOCK0:   grant0 = 1'b1;
         LOCK1:   grant1 = 1'b1;
         default: ;
      endcase
   end

   // Readies are forced low during reset so nothing is accepted in that cycle.
   assign can_take   = !res_valid || res_ready;
   assign req0_ready = grant0 && can_take && !rst;
   assign req1_ready = grant1 && can_take && !rst;
   assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   assign op_id   = grant1;
   assign op_a    = grant1 ? req1_a    : req0_a;
   assign op_b    = grant1 ? req1_b    : req0_b;
   assign op_last = grant1 ? req1_last : req0_last;
   assign cin     = (state == IDLE) ? 1'b0 : carry_q;

   cla_word_add #(.WIDTH(WIDTH)) u_add (
      .a    (op_a),
      .b    (op_b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   always_comb begin
      state_nx = state;
      rr_nx    = rr;
      if (state != IDLE && state != LOCK0 && state != LOCK1) begin
         state_nx = IDLE;
      end else if (xfer) begin
         if (op_last) begin
            state_nx = IDLE;
            rr_nx    = ~op_id;
         end else begin
            state_nx = op_id ? LOCK1 : LOCK0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr        <= 1'b0;
         carry_q   <= 1'b0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_id    <= 1'b0;
         res_last  <= 1'b0;
      end else begin
         state <= state_nx;
         rr    <= rr_nx;
         if (xfer) begin
            carry_q   <= cout;
            res_valid <= 1'b1;
            res_sum   <= sum;
            res_cout  <= cout;
            res_id    <= op_id;
            res_last  <= op_last;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_add_share_scheduler.sv
// Directed and randomized checks of the shared add scheduler against a
// transaction-level reference (round-robin operation order, wide-add carry chain).
module tb_add_share_scheduler;

   localparam int W = 64;
   localparam logic [W-1:0] ONES = {W{1'b1}};
   localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req0_last;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_last;
   logic [W-1:0] req1_a, req1_b;
   logic         res_valid, res_ready, res_cout, res_id, res_last;
   logic [W-1:0] res_sum;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   add_share_scheduler #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_b(req0_b), .req0_last(req0_last),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_b(req1_b), .req1_last(req1_last),
      .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
      .res_cout(res_cout), .res_id(res_id), .res_last(res_last)
   );

   task automatic chk(input string tag, input logic [W+3:0] obs, input logic [W+3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic l);
      req0_valid = v; req0_a = a; req0_b = b; req0_last = l;
   endtask

   task automatic drive1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic l);
      req1_valid = v; req1_a = a; req1_b = b; req1_last = l;
   endtask

   task automatic chk_res(input string tag, input logic [W-1:0] s, input logic c,
                          input logic id, input logic l);
      chk({tag, "_valid"}, res_valid, 1'b1);
      chk({tag, "_sum"},   res_sum,   s);
      chk({tag, "_cout"},  res_cout,  c);
      chk({tag, "_id"},    res_id,    id);
      chk({tag, "_last"},  res_last,  l);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Random-phase stimulus and reference
   logic [W-1:0] wa0[$], wb0[$], wa1[$], wb1[$];
   logic         wl0[$], wl1[$];
   logic [W+2:0] expq[$];

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] w;
      w = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0: w = ONES;
         1: w = '0;
         default: ;
      endcase
      return w;
   endfunction

   task automatic gen_ops(input int n_ops, output logic [W-1:0] qa[$], output logic [W-1:0] qb[$],
                          output logic ql[$]);
      int len;
      qa = {}; qb = {}; ql = {};
      for (int o = 0; o < n_ops; o++) begin
         len = $urandom_range(1, 4);
         for (int k = 0; k < len; k++) begin
            qa.push_back(rnd_word());
            qb.push_back(rnd_word());
            ql.push_back(k == len - 1);
         end
      end
   endtask

   // Expected result words for one whole operation: wide add, carry chained per word.
   task automatic model_op(input logic id, inout int p);
      logic       c;
      logic [W:0] s;
      logic       l;
      c = 1'b0;
      do begin
         if (id) begin
            s = {1'b0, wa1[p]} + {1'b0, wb1[p]} + {{W{1'b0}}, c}; l = wl1[p];
         end else begin
            s = {1'b0, wa0[p]} + {1'b0, wb0[p]} + {{W{1'b0}}, c}; l = wl0[p];
         end
         c = s[W];
         expq.push_back({s[W-1:0], c, id, l});
         p++;
      end while (!l);
   endtask

   initial begin
      int p0, p1, idx0, idx1, cyc, turn;
      logic x0, x1, held;
      logic [W+2:0] prev, exp_w;

      rst = 1'b1;
      res_ready = 1'b0;
      drive0(1'b1, 64'd1, 64'd1, 1'b1);
      drive1(1'b1, 64'd2, 64'd2, 1'b1);
      tick();
      #1;
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_ready1", req1_ready, 1'b0);
      tick();
      chk("rst_valid", res_valid, 1'b0);
      chk("rst_sum",   res_sum,   '0);
      chk("rst_meta",  {res_cout, res_id, res_last}, 3'b000);
      drive0(1'b0, '0, '0, 1'b0);
      drive1(1'b0, '0, '0, 1'b0);
      rst = 1'b0;
      res_ready = 1'b1;
      tick();

      // Single word from requester 0
      drive0(1'b1, 64'd5, 64'd7, 1'b1);
      #1;
      chk("single_ready0", req0_ready, 1'b1);
      tick();
      drive0(1'b0, '0, '0, 1'b0);
      chk_res("single", 64'd12, 1'b0, 1'b0, 1'b1);
      tick();
      chk("single_clear", res_valid, 1'b0);

      // Two-word op from requester 1 with carry across words
      drive1(1'b1, MSB, MSB, 1'b0);
      #1;
      chk("two_ready1", req1_ready, 1'b1);
      tick();
      chk_res("two_w0", '0, 1'b1, 1'b1, 1'b0);
      drive1(1'b1, 64'd1, 64'd2, 1'b1);
      tick();
      chk_res("two_w1", 64'd4, 1'b0, 1'b1, 1'b1);
      drive1(1'b0, '0, '0, 1'b0);

      // Alternating grants after reset with both requesters busy
      do_reset();
      drive0(1'b1, 64'd100, 64'd0, 1'b1);
      drive1(1'b1, 64'd200, 64'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("alt_ready", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
         tick();
         chk("alt_id", res_id, i % 2);
      end

      // Three-word lock by requester 0 while requester 1 waits
      drive0(1'b1, ONES, 64'd1, 1'b0);
      #1;
      chk("lock_w0_rdy", {req0_ready, req1_ready}, 2'b10);
      tick();
      chk_res("lock_w0", '0, 1'b1, 1'b0, 1'b0);
      drive0(1'b1, 64'd0, 64'd0, 1'b0);
      #1;
      chk("lock_w1_rdy", {req0_ready, req1_ready}, 2'b10);
      tick();
      chk_res("lock_w1", 64'd1, 1'b0, 1'b0, 1'b0);
      drive0(1'b1, 64'd3, 64'd4, 1'b1);
      #1;
      chk("lock_w2_rdy", {req0_ready, req1_ready}, 2'b10);
      tick();
      chk_res("lock_w2", 64'd7, 1'b0, 1'b0, 1'b1);
      drive1(1'b1, 64'd10, 64'd20, 1'b1);
      #1;
      chk("after_lock_rdy", {req0_ready, req1_ready}, 2'b01);
      tick();
      chk_res("after_lock", 64'd30, 1'b0, 1'b1, 1'b1);

      // Backpressure: result, readies and chained carry frozen
      drive1(1'b0, '0, '0, 1'b0);
      drive0(1'b1, ONES, 64'd1, 1'b0);
      tick();
      chk_res("bp_w0", '0, 1'b1, 1'b0, 1'b0);
      res_ready = 1'b0;
      drive0(1'b1, 64'd5, 64'd6, 1'b1);
      drive1(1'b1, 64'd9, 64'd9, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", {req0_ready, req1_ready}, 2'b00);
         tick();
         chk_res("bp_hold", '0, 1'b1, 1'b0, 1'b0);
      end
      res_ready = 1'b1;
      drive1(1'b0, '0, '0, 1'b0);
      tick();
      chk_res("bp_w1", 64'd12, 1'b0, 1'b0, 1'b1);
      drive0(1'b0, '0, '0, 1'b0);
      tick();

      // Reset in the middle of a requester-1 operation
      drive1(1'b1, ONES, 64'd1, 1'b0);
      tick();
      chk_res("abort_w0", '0, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk("abort_rst_rdy", {req0_ready, req1_ready}, 2'b00);
      tick();
      rst = 1'b0;
      chk("abort_valid", res_valid, 1'b0);
      drive1(1'b1, 64'd2, 64'd3, 1'b1);
      tick();
      chk_res("abort_new", 64'd5, 1'b0, 1'b1, 1'b1);
      drive1(1'b0, '0, '0, 1'b0);

      // Randomized: both requesters backlogged, random consumer stalls
      do_reset();
      gen_ops(6, wa0, wb0, wl0);
      gen_ops(6, wa1, wb1, wl1);
      expq = {};
      p0 = 0; p1 = 0; turn = 0;
      while (p0 < wa0.size() || p1 < wa1.size()) begin
         if (p1 >= wa1.size() || (p0 < wa0.size() && turn == 0)) model_op(1'b0, p0);
         else                                                    model_op(1'b1, p1);
         turn = 1 - turn;
      end
      idx0 = 0; idx1 = 0; cyc = 0; held = 1'b0; prev = '0;
      while (expq.size() > 0 && cyc < 5000) begin
         if (idx0 < wa0.size()) drive0(1'b1, wa0[idx0], wb0[idx0], wl0[idx0]);
         else                   drive0(1'b0, '0, '0, 1'b0);
         if (idx1 < wa1.size()) drive1(1'b1, wa1[idx1], wb1[idx1], wl1[idx1]);
         else                   drive1(1'b0, '0, '0, 1'b0);
         res_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (req0_ready && req1_ready) chk("rnd_one_ready", {req0_ready, req1_ready}, 2'b00);
         if (held) chk("rnd_hold", {res_valid, res_sum, res_cout, res_id, res_last}, {1'b1, prev});
         if (res_valid && !res_ready) begin
            chk("rnd_stall_rdy", {req0_ready, req1_ready}, 2'b00);
            held = 1'b1;
            prev = {res_sum, res_cout, res_id, res_last};
         end else begin
            held = 1'b0;
         end
         if (res_valid && res_ready) begin
            exp_w = expq.pop_front();
            chk("rnd_word", {res_sum, res_cout, res_id, res_last}, exp_w);
         end
         x0 = req0_valid && req0_ready;
         x1 = req1_valid && req1_ready;
         tick();
         if (x0) idx0++;
         if (x1) idx1++;
         cyc++;
      end
      chk("rnd_drained", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
